mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter_pkg.sv | 24 ++
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared types for the core memory-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SERVE_IF  = 2'd1,
        SERVE_LSU = 2'd2,
        DRAIN     = 2'd3
    } arb_state_t;

    typedef enum logic {
        SRC_IF  = 1'b0,
        SRC_LSU = 1'b1
    } src_t;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Single-outstanding arbiter sharing the memory port between
//               instruction fetch and the load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int BITSIZE      = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               resetn_i,
    input  logic               branch_taken_i,
    input  logic [BITSIZE-1:0] IF_addr_i,
    input  logic               IF_read_i,
    output logic [31:0]        IF_data_o,
    output logic               IF_valid_o,
    input  logic [BITSIZE-1:0] LSU_addr_i,
    input  logic [31:0]        LSU_wdata_i,
    input  logic [3:0]         LSU_be_i,
    input  logic               LSU_read_i,
    input  logic               LSU_write_i,
    output logic [31:0]        LSU_data_o,
    output logic               LSU_valid_o,
    output logic [BITSIZE-1:0] MEM_addr_o,
    output logic [31:0]        MEM_wdata_o,
    output logic [3:0]         MEM_be_o,
    output logic               MEM_read_o,
    output logic               MEM_write_o,
    input  logic [31:0]        MEM_data_i,
    input  logic               MEM_valid_i
);

    localparam logic [3:0] C_STARVE_LIMIT = 4'(STARVE_LIMIT);

    arb_state_t state;
    logic [3:0] starve_cnt;

    logic       lsu_req;
    logic       if_req;
    logic       grant_valid;
    src_t       grant_src;

    // A fetch that is being flushed this cycle is not worth starting.
    assign lsu_req = LSU_read_i | LSU_write_i;
    assign if_req  = IF_read_i & ~branch_taken_i;

    always_comb begin
        grant_valid = 1'b0;
        grant_src   = SRC_LSU;
        if (if_req && (!lsu_req || starve_cnt == C_STARVE_LIMIT)) begin
            grant_valid = 1'b1;
            grant_src   = SRC_IF;
        end else if (lsu_req) begin
            grant_valid = 1'b1;
            grant_src   = SRC_LSU;
        end
    end

    assign IF_valid_o  = (state == SERVE_IF) & MEM_valid_i & ~branch_taken_i;
    assign LSU_valid_o = (state == SERVE_LSU) & MEM_valid_i;
    assign IF_data_o   = MEM_data_i;
    assign LSU_data_o  = MEM_data_i;

    always_ff @(posedge clk or negedge resetn_i) begin
        if (!resetn_i) begin
            state       <= IDLE;
            starve_cnt  <= 4'd0;
            MEM_read_o  <= 1'b0;
            MEM_write_o <= 1'b0;
            MEM_addr_o  <= '0;
            MEM_wdata_o <= 32'd0;
            MEM_be_o    <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid && grant_src == SRC_IF) begin
                        state       <= SERVE_IF;
                        MEM_addr_o  <= IF_addr_i;
                        MEM_be_o    <= 4'hF;
                        MEM_read_o  <= 1'b1;
                        MEM_write_o <= 1'b0;
                        starve_cnt  <= 4'd0;
                    end else if (grant_valid) begin
                        state       <= SERVE_LSU;
                        MEM_addr_o  <= LSU_addr_i;
                        MEM_wdata_o <= LSU_wdata_i;
                        MEM_be_o    <= LSU_be_i;
                        // A simultaneous read+write request is treated as a write.
                        MEM_write_o <= LSU_write_i;
                        MEM_read_o  <= LSU_read_i & ~LSU_write_i;
                        if (!IF_read_i)
                            starve_cnt <= 4'd0;
                        else if (starve_cnt < C_STARVE_LIMIT)
                            starve_cnt <= starve_cnt + 4'd1;
                    end else if (!IF_read_i) begin
                        starve_cnt <= 4'd0;
                    end
                end
                SERVE_IF: begin
                    if (MEM_valid_i) begin
                        state      <= IDLE;
                        MEM_read_o <= 1'b0;
                    end else if (branch_taken_i) begin
                        state <= DRAIN;
                    end
                end
                SERVE_LSU: begin
                    if (MEM_valid_i) begin
                        state       <= IDLE;
                        MEM_read_o  <= 1'b0;
                        MEM_write_o <= 1'b0;
                    end
                end
                DRAIN: begin
                    // Keep the read strobe up so the memory can retire the killed fetch.
                    if (MEM_valid_i) begin
                        state      <= IDLE;
                        MEM_read_o <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    MEM_read_o  <= 1'b0;
                    MEM_write_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed, table-driven self-checking bench for mem_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        resetn_i;
    logic        branch_taken_i;
    logic [31:0] IF_addr_i;
    logic        IF_read_i;
    logic [31:0] IF_data_o;
    logic        IF_valid_o;
    logic [31:0] LSU_addr_i;
    logic [31:0] LSU_wdata_i;
    logic [3:0]  LSU_be_i;
    logic        LSU_read_i;
    logic        LSU_write_i;
    logic [31:0] LSU_data_o;
    logic        LSU_valid_o;
    logic [31:0] MEM_addr_o;
    logic [31:0] MEM_wdata_o;
    logic [3:0]  MEM_be_o;
    logic        MEM_read_o;
    logic        MEM_write_o;
    logic [31:0] MEM_data_i;
    logic        MEM_valid_i;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(.BITSIZE(32), .STARVE_LIMIT(4)) dut (
        .clk            (clk),
        .resetn_i       (resetn_i),
        .branch_taken_i (branch_taken_i),
        .IF_addr_i      (IF_addr_i),
        .IF_read_i      (IF_read_i),
        .IF_data_o      (IF_data_o),
        .IF_valid_o     (IF_valid_o),
        .LSU_addr_i     (LSU_addr_i),
        .LSU_wdata_i    (LSU_wdata_i),
        .LSU_be_i       (LSU_be_i),
        .LSU_read_i     (LSU_read_i),
        .LSU_write_i    (LSU_write_i),
        .LSU_data_o     (LSU_data_o),
        .LSU_valid_o    (LSU_valid_o),
        .MEM_addr_o     (MEM_addr_o),
        .MEM_wdata_o    (MEM_wdata_o),
        .MEM_be_o       (MEM_be_o),
        .MEM_read_o     (MEM_read_o),
        .MEM_write_o    (MEM_write_o),
        .MEM_data_i     (MEM_data_i),
        .MEM_valid_i    (MEM_valid_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        if_rd;
        logic [31:0] if_addr;
        logic        lsu_rd;
        logic        lsu_wr;
        logic [31:0] lsu_addr;
        logic [31:0] lsu_wdata;
        logic [3:0]  lsu_be;
        logic        br;
        logic        mv;
        logic [31:0] md;
        logic        e_rd;
        logic        e_wr;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic        e_ifv;
        logic        e_lsv;
    } vec_t;

    function automatic vec_t v(
        input logic if_rd, input logic [31:0] if_addr,
        input logic lsu_rd, input logic lsu_wr, input logic [31:0] lsu_addr,
        input logic [31:0] lsu_wdata, input logic [3:0] lsu_be,
        input logic br, input logic mv, input logic [31:0] md,
        input logic e_rd, input logic e_wr, input logic [31:0] e_addr,
        input logic [3:0] e_be, input logic e_ifv, input logic e_lsv);
        vec_t r;
        r.if_rd = if_rd;   r.if_addr = if_addr;
        r.lsu_rd = lsu_rd; r.lsu_wr = lsu_wr; r.lsu_addr = lsu_addr;
        r.lsu_wdata = lsu_wdata; r.lsu_be = lsu_be;
        r.br = br; r.mv = mv; r.md = md;
        r.e_rd = e_rd; r.e_wr = e_wr; r.e_addr = e_addr; r.e_be = e_be;
        r.e_ifv = e_ifv; r.e_lsv = e_lsv;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        branch_taken_i = 1'b0;
        IF_read_i = 1'b0;   IF_addr_i = 32'd0;
        LSU_read_i = 1'b0;  LSU_write_i = 1'b0;
        LSU_addr_i = 32'd0; LSU_wdata_i = 32'd0; LSU_be_i = 4'd0;
        MEM_valid_i = 1'b0; MEM_data_i = 32'd0;
    endtask

    // Inputs change on the falling edge; outputs are checked shortly before the rising edge.
    task automatic run_row(input string tag, input vec_t r);
        @(negedge clk);
        IF_read_i = r.if_rd;     IF_addr_i = r.if_addr;
        LSU_read_i = r.lsu_rd;   LSU_write_i = r.lsu_wr;
        LSU_addr_i = r.lsu_addr; LSU_wdata_i = r.lsu_wdata; LSU_be_i = r.lsu_be;
        branch_taken_i = r.br;   MEM_valid_i = r.mv; MEM_data_i = r.md;
        #3;
        chk({tag, ".mem_read"},  32'(MEM_read_o),  32'(r.e_rd));
        chk({tag, ".mem_write"}, 32'(MEM_write_o), 32'(r.e_wr));
        chk({tag, ".mem_addr"},  MEM_addr_o,       r.e_addr);
        chk({tag, ".mem_be"},    32'(MEM_be_o),    32'(r.e_be));
        chk({tag, ".if_valid"},  32'(IF_valid_o),  32'(r.e_ifv));
        chk({tag, ".lsu_valid"}, 32'(LSU_valid_o), 32'(r.e_lsv));
        if (r.e_ifv) chk({tag, ".if_data"}, IF_data_o, r.md);
        if (r.e_lsv) chk({tag, ".lsu_data"}, LSU_data_o, r.md);
        if (r.e_wr)  chk({tag, ".mem_wdata"}, MEM_wdata_o, r.lsu_wdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[10];
        vec_t seq_c[3];
        vec_t seq_f[7];
        int   got[$];
        int   exp_src[6];
        int   cyc;

        // IF-only fetch with two wait cycles, then a collision where LSU stores first.
        tbl[0] = v(1, 32'h100, 0,0, 32'h0, 32'h0, 4'h0,        0,0, 32'h0,        0,0, 32'h0,    4'h0, 0,0);
        tbl[1] = v(1, 32'h100, 0,0, 32'h0, 32'h0, 4'h0,        0,0, 32'h0,        1,0, 32'h100,  4'hF, 0,0);
        tbl[2] = v(1, 32'h100, 0,0, 32'h0, 32'h0, 4'h0,        0,0, 32'h0,        1,0, 32'h100,  4'hF, 0,0);
        tbl[3] = v(1, 32'h100, 0,0, 32'h0, 32'h0, 4'h0,        0,1, 32'h13,       1,0, 32'h100,  4'hF, 1,0);
        tbl[4] = v(0, 32'h0,   0,0, 32'h0, 32'h0, 4'h0,        0,0, 32'h0,        0,0, 32'h100,  4'hF, 0,0);
        tbl[5] = v(1, 32'h104, 0,1, 32'h2000, 32'hDEADBEEF, 4'h3, 0,0, 32'h0,     0,0, 32'h100,  4'hF, 0,0);
        tbl[6] = v(1, 32'h104, 0,1, 32'h2000, 32'hDEADBEEF, 4'h3, 0,1, 32'h0,     0,1, 32'h2000, 4'h3, 0,1);
        tbl[7] = v(1, 32'h104, 0,0, 32'h0, 32'h0, 4'h0,        0,0, 32'h0,        0,0, 32'h2000, 4'h3, 0,0);
        tbl[8] = v(1, 32'h104, 0,0, 32'h0, 32'h0, 4'h0,        0,1, 32'hAAAA5555, 1,0, 32'h104,  4'hF, 1,0);
        tbl[9] = v(0, 32'h0,   0,0, 32'h0, 32'h0, 4'h0,        0,0, 32'h0,        0,0, 32'h104,  4'hF, 0,0);

        // Branch coincident with memory completion.
        seq_c[0] = v(1, 32'h400, 0,0, 32'h0, 32'h0, 4'h0, 0,0, 32'h0,  0,0, 32'h104, 4'hF, 0,0);
        seq_c[1] = v(1, 32'h400, 0,0, 32'h0, 32'h0, 4'h0, 1,1, 32'h99, 1,0, 32'h400, 4'hF, 0,0);
        seq_c[2] = v(0, 32'h0,   0,0, 32'h0, 32'h0, 4'h0, 0,0, 32'h0,  0,0, 32'h400, 4'hF, 0,0);

        // Branch one cycle after grant, memory answers three cycles later.
        seq_f[0] = v(1, 32'h500, 0,0, 32'h0, 32'h0, 4'h0, 0,0, 32'h0,  0,0, 32'h400, 4'hF, 0,0);
        seq_f[1] = v(1, 32'h500, 0,0, 32'h0, 32'h0, 4'h0, 0,0, 32'h0,  1,0, 32'h500, 4'hF, 0,0);
        seq_f[2] = v(0, 32'h0,   0,0, 32'h0, 32'h0, 4'h0, 1,0, 32'h0,  1,0, 32'h500, 4'hF, 0,0);
        seq_f[3] = v(0, 32'h0,   0,0, 32'h0, 32'h0, 4'h0, 0,0, 32'h0,  1,0, 32'h500, 4'hF, 0,0);
        seq_f[4] = v(0, 32'h0,   0,0, 32'h0, 32'h0, 4'h0, 0,0, 32'h0,  1,0, 32'h500, 4'hF, 0,0);
        seq_f[5] = v(0, 32'h0,   0,0, 32'h0, 32'h0, 4'h0, 0,1, 32'h77, 1,0, 32'h500, 4'hF, 0,0);
        seq_f[6] = v(0, 32'h0,   0,0, 32'h0, 32'h0, 4'h0, 0,0, 32'h0,  0,0, 32'h500, 4'hF, 0,0);

        exp_src = '{2, 2, 2, 2, 1, 2};

        drive_idle();
        resetn_i = 1'b0;
        IF_read_i = 1'b1; LSU_write_i = 1'b1; MEM_valid_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.mem_read",  32'(MEM_read_o),  32'd0);
        chk("reset.mem_write", 32'(MEM_write_o), 32'd0);
        chk("reset.mem_addr",  MEM_addr_o,       32'd0);
        chk("reset.mem_wdata", MEM_wdata_o,      32'd0);
        chk("reset.mem_be",    32'(MEM_be_o),    32'd0);
        chk("reset.if_valid",  32'(IF_valid_o),  32'd0);
        chk("reset.lsu_valid", 32'(LSU_valid_o), 32'd0);
        @(negedge clk);
        drive_idle();
        resetn_i = 1'b1;

        for (int i = 0; i < 10; i++) run_row($sformatf("tbl%0d", i), tbl[i]);
        for (int i = 0; i < 3; i++)  run_row($sformatf("coinc%0d", i), seq_c[i]);
        for (int i = 0; i < 7; i++)  run_row($sformatf("flush%0d", i), seq_f[i]);

        // Starvation: LSU and IF both request continuously, zero-wait memory.
        cyc = 0;
        while (got.size() < 6 && cyc < 60) begin
            @(negedge clk);
            IF_read_i = 1'b1;  IF_addr_i = 32'h300;
            LSU_read_i = 1'b1; LSU_addr_i = 32'h600; LSU_be_i = 4'hF;
            MEM_valid_i = MEM_read_o | MEM_write_o;
            MEM_data_i = 32'h1111_0000 + 32'(cyc);
            #3;
            if (IF_valid_o)  got.push_back(1);
            if (LSU_valid_o) got.push_back(2);
            cyc++;
        end
        chk("starve.completions", 32'(got.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("starve.src%0d", i), (i < got.size()) ? 32'(got[i]) : 32'd0, 32'(exp_src[i]));
        @(negedge clk);
        drive_idle();
        @(negedge clk);

        // Asynchronous reset in the middle of an LSU load.
        run_row("rst0", v(0,32'h0, 1,0, 32'h700, 32'h0, 4'hC, 0,0, 32'h0, 0,0, 32'h600, 4'hF, 0,0));
        run_row("rst1", v(0,32'h0, 1,0, 32'h700, 32'h0, 4'hC, 0,0, 32'h0, 1,0, 32'h700, 4'hC, 0,0));
        @(negedge clk);
        MEM_valid_i = 1'b1;
        #1 resetn_i = 1'b0;
        #1;
        chk("rst.mem_read",  32'(MEM_read_o),  32'd0);
        chk("rst.mem_write", 32'(MEM_write_o), 32'd0);
        chk("rst.lsu_valid", 32'(LSU_valid_o), 32'd0);
        chk("rst.mem_addr",  MEM_addr_o,       32'd0);
        chk("rst.mem_be",    32'(MEM_be_o),    32'd0);
        @(negedge clk);
        LSU_read_i = 1'b0;
        resetn_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (i > 0) @(negedge clk);
            #3;
            chk($sformatf("stale%0d.lsu_valid", i), 32'(LSU_valid_o), 32'd0);
            chk($sformatf("stale%0d.mem_read", i),  32'(MEM_read_o),  32'd0);
        end
        @(negedge clk);
        drive_idle();
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
